// File: rtl/user_irq_pkg.sv
// Shared register map, bit positions and helpers for the user_irq_compare block.
package user_irq_pkg;

   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_COMPARE = 3'd1;
   localparam logic [2:0] REG_PERIOD  = 3'd2;
   localparam logic [2:0] REG_STATUS  = 3'd3;
   localparam logic [2:0] REG_MCOUNT  = 3'd4;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IE       = 2;

   localparam int STATUS_PEND = 0;
   localparam int STATUS_OVR  = 1;

   localparam int MCOUNT_W = 16;

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lane_sel);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (lane_sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/user_irq_compare_if.sv
// Wishbone slave-side signal bundle for the compare/interrupt unit.
interface user_irq_compare_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/count_matcher.sv
// COMPARE register with periodic reload plus rising-edge match detection.
module count_matcher
   import user_irq_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic            clk_i,
   input  logic            srst_i,
   input  logic            en_i,
   input  logic            periodic_i,
   input  logic [BITS-1:0] count_i,
   input  logic [BITS-1:0] period_i,
   input  logic            wr_i,
   input  logic [31:0]     wdata_i,
   input  logic [3:0]      wsel_i,
   output logic [BITS-1:0] compare_o,
   output logic            event_o
);

   logic            hit;
   logic            hit_d_q, hit_d_d;
   logic [BITS-1:0] compare_q, compare_d;

   assign hit       = en_i & (count_i == compare_q);
   assign event_o   = hit & ~hit_d_q;
   assign compare_o = compare_q;

   // A software write always beats a same-cycle periodic reload.
   always_comb begin
      hit_d_d   = hit;
      compare_d = compare_q;
      if (wr_i) begin
         compare_d = BITS'(merge_lanes(32'(compare_q), wdata_i, wsel_i));
      end else if (event_o && periodic_i) begin
         compare_d = compare_q + period_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         hit_d_q   <= 1'b0;
         compare_q <= '0;
      end else begin
         hit_d_q   <= hit_d_d;
         compare_q <= compare_d;
      end
   end

endmodule

// File: rtl/user_irq_compare.sv
// Wishbone-mapped compare unit: raises user irq lines when the watched count hits COMPARE.
module user_irq_compare
   import user_irq_pkg::*;
#(
   parameter int          BITS      = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   user_irq_compare_if.slave  wb,
   input  logic [BITS-1:0]    count_i,
   output logic [2:0]         irq
);

   logic                sel, accept, wr;
   logic [2:0]          offset;
   logic                wr_ctrl, wr_compare, wr_period, wr_status, wr_mcount;
   logic                clr_pend, clr_ovr;
   logic                evt;
   logic [BITS-1:0]     compare;
   logic [31:0]         rd_data;

   logic                ack_q, ack_d;
   logic [31:0]         dat_q, dat_d;
   logic [2:0]          ctrl_q, ctrl_d;
   logic [BITS-1:0]     period_q, period_d;
   logic                pend_q, pend_d;
   logic                ovr_q, ovr_d;
   logic [MCOUNT_W-1:0] mcount_q, mcount_d;

   logic                unused_adr_bits;
   assign unused_adr_bits = ^{wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0]};

   assign sel    = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign accept = sel & ~ack_q;
   assign wr     = accept & wb.wbs_we_i;
   assign offset = wb.wbs_adr_i[4:2];

   assign wr_ctrl    = wr & (offset == REG_CTRL);
   assign wr_compare = wr & (offset == REG_COMPARE);
   assign wr_period  = wr & (offset == REG_PERIOD);
   assign wr_status  = wr & (offset == REG_STATUS);
   assign wr_mcount  = wr & (offset == REG_MCOUNT);

   assign clr_pend = wr_status & wb.wbs_sel_i[0] & wb.wbs_dat_i[STATUS_PEND];
   assign clr_ovr  = wr_status & wb.wbs_sel_i[0] & wb.wbs_dat_i[STATUS_OVR];

   count_matcher #(.BITS(BITS)) u_matcher (
      .clk_i      (wb_clk_i),
      .srst_i     (wb_rst_i),
      .en_i       (ctrl_q[CTRL_EN]),
      .periodic_i (ctrl_q[CTRL_PERIODIC]),
      .count_i    (count_i),
      .period_i   (period_q),
      .wr_i       (wr_compare),
      .wdata_i    (wb.wbs_dat_i),
      .wsel_i     (wb.wbs_sel_i),
      .compare_o  (compare),
      .event_o    (evt)
   );

   always_comb begin
      rd_data = 32'h0;
      case (offset)
         REG_CTRL:    rd_data = {29'h0, ctrl_q};
         REG_COMPARE: rd_data = 32'(compare);
         REG_PERIOD:  rd_data = 32'(period_q);
         REG_STATUS:  rd_data = {30'h0, ovr_q, pend_q};
         REG_MCOUNT:  rd_data = 32'(mcount_q);
         default:     rd_data = 32'h0;
      endcase
   end

   // Clears are applied first so a same-edge event still leaves PEND set,
   // and a cleared PEND cannot turn that event into an overrun.
   always_comb begin
      ack_d    = sel & ~ack_q;
      dat_d    = accept ? rd_data : dat_q;
      ctrl_d   = ctrl_q;
      period_d = period_q;
      if (wr_ctrl && wb.wbs_sel_i[0]) ctrl_d = wb.wbs_dat_i[2:0];
      if (wr_period) period_d = BITS'(merge_lanes(32'(period_q), wb.wbs_dat_i, wb.wbs_sel_i));
      pend_d = evt | (pend_q & ~clr_pend);
      ovr_d  = (ovr_q & ~clr_ovr) | (evt & pend_q & ~clr_pend);
      if (wr_mcount) begin
         mcount_d = '0;
      end else if (evt && (mcount_q != '1)) begin
         mcount_d = mcount_q + 1'b1;
      end else begin
         mcount_d = mcount_q;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= 32'h0;
         ctrl_q   <= 3'h0;
         period_q <= '0;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
         mcount_q <= '0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
         mcount_q <= mcount_d;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign irq = {1'b0, ovr_q & ctrl_q[CTRL_IE], pend_q & ctrl_q[CTRL_IE]};

endmodule

// File: tb/tb_user_irq_compare.sv
// Directed bench for user_irq_compare; register reads are checked by a scoreboard monitor.
module tb_user_irq_compare;

   localparam logic [31:0] BASE = 32'h3000_0100;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_CMP  = BASE + 32'h04;
   localparam logic [31:0] A_PER  = BASE + 32'h08;
   localparam logic [31:0] A_STAT = BASE + 32'h0C;
   localparam logic [31:0] A_MCNT = BASE + 32'h10;
   localparam logic [31:0] A_RSV  = BASE + 32'h14;

   logic        clk = 1'b0;
   logic        srst = 1'b1;
   logic [31:0] count = 32'h0;
   logic [2:0]  irq;

   int n_vec = 0;
   int n_err = 0;

   logic [32:0] exp_q[$];
   string       nm_q[$];

   user_irq_compare_if bus();

   user_irq_compare #(.BITS(32), .BASE_ADDR(BASE)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (srst),
      .wb       (bus.slave),
      .count_i  (count),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every ack pops one scoreboard entry; read entries are compared.
   initial begin
      logic [32:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 32'd1, 32'd0);
            end else begin
               e  = exp_q.pop_front();
               nm = nm_q.pop_front();
               if (e[32]) check(nm, bus.wbs_dat_o, e[31:0]);
               $display("%0t ack %s dat_o=0x%08h", $time, nm, bus.wbs_dat_o);
            end
         end
      end
   end

   task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sl, input bit is_rd, input logic [31:0] exp,
                       input string nm, input bit expect_ack, input bit set_cnt,
                       input logic [31:0] cnt, output int waited);
      bit got;
      @(negedge clk);
      if (expect_ack) begin
         exp_q.push_back({is_rd, exp});
         nm_q.push_back(nm);
      end
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sl;
      if (set_cnt) count = cnt;
      got    = 1'b0;
      waited = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         waited++;
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      if (expect_ack && !got) begin
         check({nm, "_ack_timeout"}, 32'd0, 32'd1);
         void'(exp_q.pop_back());
         void'(nm_q.pop_back());
      end
      if (!expect_ack) check({nm, "_no_ack"}, 32'(got), 32'd0);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sl);
      int w;
      xfer(1'b1, adr, dat, sl, 1'b0, 32'h0, "write", 1'b1, 1'b0, 32'h0, w);
   endtask

   task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
      int w;
      xfer(1'b0, adr, 32'h0, 4'hF, 1'b1, exp, nm, 1'b1, 1'b0, 32'h0, w);
   endtask

   initial begin
      int w;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
      check("rst_dat", bus.wbs_dat_o, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      srst = 1'b0;
      rd(A_CTRL, 32'h0, "rst_ctrl");
      rd(A_CMP,  32'h0, "rst_compare");
      rd(A_PER,  32'h0, "rst_period");
      rd(A_STAT, 32'h0, "rst_status");
      rd(A_MCNT, 32'h0, "rst_mcount");
      xfer(1'b0, A_RSV, 32'h0, 4'hF, 1'b1, 32'h0, "rsv_0x14", 1'b1, 1'b0, 32'h0, w);
      check("rsv_ack_latency", 32'(w), 32'd1);
      check("irq_after_reset", 32'(irq), 32'd0);

      // Single match with ramping count
      wr(A_CMP, 32'h10, 4'hF);
      wr(A_CTRL, 32'h5, 4'hF);
      for (int v = 14; v <= 18; v++) begin
         @(negedge clk);
         if (v == 16) check("irq_before_match", 32'(irq), 32'd0);
         count = 32'(v);
         if (v == 16) begin
            @(negedge clk);
            check("irq0_after_match", 32'(irq), 32'd1);
         end
      end
      rd(A_STAT, 32'h1, "ramp_status");
      rd(A_MCNT, 32'h1, "ramp_mcount");

      // Periodic reload with wrap-around, then overrun
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_STAT, 32'h3, 4'hF);
      wr(A_MCNT, 32'h0, 4'hF);
      @(negedge clk) count = 32'h0;
      wr(A_CMP, 32'hFFFF_FFF0, 4'hF);
      wr(A_PER, 32'h20, 4'hF);
      wr(A_CTRL, 32'h7, 4'hF);
      @(negedge clk) count = 32'hFFFF_FFF0;
      @(negedge clk) count = 32'h0;
      check("per_irq_pend", 32'(irq), 32'd1);
      rd(A_CMP, 32'h10, "per_compare_wrap");
      rd(A_STAT, 32'h1, "per_status1");
      @(negedge clk) count = 32'h10;
      @(negedge clk) count = 32'h11;
      check("per_irq_ovr", 32'(irq), 32'd3);
      rd(A_STAT, 32'h3, "per_status_ovr");
      rd(A_MCNT, 32'h2, "per_mcount");
      rd(A_CMP, 32'h30, "per_compare2");

      // Counter frozen on COMPARE gives one event; re-enable while equal fires
      wr(A_CTRL, 32'h0, 4'hF);
      @(negedge clk) count = 32'h10;
      wr(A_STAT, 32'h3, 4'hF);
      wr(A_MCNT, 32'h0, 4'hF);
      wr(A_CMP, 32'h10, 4'hF);
      wr(A_CTRL, 32'h5, 4'hF);
      repeat (50) @(negedge clk);
      rd(A_MCNT, 32'h1, "hold_mcount");
      rd(A_STAT, 32'h1, "hold_status");
      wr(A_STAT, 32'h3, 4'hF);
      rd(A_STAT, 32'h0, "hold_status_clr");
      check("hold_irq_clr", 32'(irq), 32'd0);

      // W1C of PEND on the same edge as an event
      @(negedge clk) count = 32'h0;
      @(negedge clk) count = 32'h10;
      @(negedge clk) count = 32'h0;
      @(negedge clk);
      xfer(1'b1, A_STAT, 32'h1, 4'hF, 1'b0, 32'h0, "w1c_race", 1'b1, 1'b1, 32'h10, w);
      rd(A_STAT, 32'h1, "w1c_race_status");
      rd(A_MCNT, 32'h3, "w1c_race_mcount");

      // MCOUNT write on the same edge as an event
      @(negedge clk) count = 32'h0;
      @(negedge clk);
      xfer(1'b1, A_MCNT, 32'h0, 4'hF, 1'b0, 32'h0, "mcnt_race", 1'b1, 1'b1, 32'h10, w);
      rd(A_MCNT, 32'h0, "mcnt_race_mcount");

      // Software COMPARE write beats a same-edge periodic reload
      wr(A_CTRL, 32'h0, 4'hF);
      @(negedge clk) count = 32'h0;
      wr(A_CMP, 32'h40, 4'hF);
      wr(A_PER, 32'h8, 4'hF);
      wr(A_CTRL, 32'h3, 4'hF);
      xfer(1'b1, A_CMP, 32'h99, 4'hF, 1'b0, 32'h0, "cmp_race", 1'b1, 1'b1, 32'h40, w);
      rd(A_CMP, 32'h99, "cmp_race_compare");

      // Byte-lane write and out-of-window access
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_CMP, 32'h1122_3344, 4'hF);
      wr(A_CMP, 32'hAABB_CCDD, 4'b0010);
      rd(A_CMP, 32'h1122_CC44, "byte_lane_compare");
      xfer(1'b1, 32'h3000_0204, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0, "out_of_window", 1'b0, 1'b0, 32'h0, w);
      rd(A_CMP, 32'h1122_CC44, "out_of_window_compare");

      // Reset during a transfer: no ack
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b1;
      bus.wbs_adr_i = A_CMP;
      bus.wbs_dat_i = 32'h55;
      srst = 1'b1;
      @(negedge clk);
      check("rst_mid_no_ack", 32'(bus.wbs_ack_o), 32'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      srst = 1'b0;
      rd(A_CMP, 32'h0, "rst_mid_compare");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
